// File: rtl/sdes_pkg.sv
// sdes_pkg: shared S-DES definitions for the scheduled engine.
//   - sdes_state_e     : controller states (IDLE, R1, R2, OUT)
//   - SDES_ENC/SDES_DEC: per-channel mode encodings
//   - S0_TAB/S1_TAB    : 4->2 S-box lookup tables
//   - p10, p8, ip, ip_inv, ep, p4 : S-DES permutations
// Bit convention: S-DES bit 1 is the MSB of each vector.
package sdes_pkg;

  typedef enum logic [1:0] {IDLE, R1, R2, OUT} sdes_state_e;

  localparam logic SDES_ENC = 1'b0;
  localparam logic SDES_DEC = 1'b1;

  // Indexed by {row, col} = {b1, b4, b2, b3} of the 4-bit S-box input.
  // NOTE: these are constant lookup tables, not storage, so there is nothing to reset.
  localparam logic [1:0] S0_TAB [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };
  localparam logic [1:0] S1_TAB [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  function automatic logic [1:0] sbox0(input logic [3:0] x);
    return S0_TAB[{x[3], x[0], x[2], x[1]}];
  endfunction

  function automatic logic [1:0] sbox1(input logic [3:0] x);
    return S1_TAB[{x[3], x[0], x[2], x[1]}];
  endfunction

  // P10 = 3 5 2 7 4 10 1 9 8 6
  function automatic logic [9:0] p10(input logic [9:0] x);
    return {x[7], x[5], x[8], x[3], x[6], x[0], x[9], x[1], x[2], x[4]};
  endfunction

  // P8 = 6 3 7 4 8 5 10 9
  function automatic logic [7:0] p8(input logic [9:0] x);
    return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
  endfunction

  // IP = 2 6 3 1 4 8 5 7
  function automatic logic [7:0] ip(input logic [7:0] x);
    return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
  endfunction

  // IP^-1 = 4 1 3 5 7 2 8 6
  function automatic logic [7:0] ip_inv(input logic [7:0] x);
    return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  // EP = 4 1 2 3 2 3 4 1
  function automatic logic [7:0] ep(input logic [3:0] x);
    return {x[0], x[3], x[2], x[1], x[2], x[1], x[0], x[3]};
  endfunction

  // P4 = 2 4 3 1
  function automatic logic [3:0] p4(input logic [3:0] x);
    return {x[2], x[0], x[1], x[3]};
  endfunction

endpackage

// File: rtl/sdes_engine_sched_fk.sv
// sdes_fk: one combinational S-DES fk round (no swap).
//   st_i  [7:0] : round state {L, R}
//   key_i [7:0] : round key
//   st_o  [7:0] : {L ^ F(R, key), R}
module sdes_fk
  import sdes_pkg::*;
(
  input  logic [7:0] st_i,
  input  logic [7:0] key_i,
  output logic [7:0] st_o
);

  logic [7:0] mix;
  logic [3:0] f;

  always_comb begin
    mix  = ep(st_i[3:0]) ^ key_i;
    f    = p4({sbox0(mix[7:4]), sbox1(mix[3:0])});
    st_o = {st_i[7:4] ^ f, st_i[3:0]};
  end

endmodule

// File: rtl/sdes_engine_sched.sv
// sdes_engine_sched: iterative S-DES engine shared by two requester channels.
// One fk unit is time-multiplexed over R1 (key A) and R2 (key B).
// Ports:
//   clk, rstn            : clock, async active-low reset
//   key_wr, key[9:0]     : load master key and derive k1/k2
//   req_valid/req_ready  : per-channel request handshake (ready one-hot, IDLE only)
//   req_mode[1:0]        : per channel 0 = encrypt, 1 = decrypt
//   req_data[15:0]       : {ch1, ch0} input blocks
//   out_valid/out_ready  : result handshake; out_data/out_id held while waiting
//   busy                 : high whenever the controller is not IDLE
// Build option: define SDES_RR_EN for round-robin arbitration on contention;
// otherwise ch0 has fixed priority and no grant pointer exists.
module sdes_engine_sched
  import sdes_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        key_wr,
  input  logic [9:0]  key,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_mode,
  input  logic [15:0] req_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_id,
  output logic        busy
);

  sdes_state_e state_q;
  logic [7:0]  st_q, ka_q, kb_q, k1_q, k2_q, out_data_q;
  logic        id_q, out_id_q, out_valid_q;

  logic [9:0]  p10_key, ls1_key, ls3_key;
  logic [7:0]  k1_d, k2_d;
  logic [1:0]  grant;
  logic        accept, gnt_ch;
  logic [7:0]  fk_key, fk_out;

  // Key schedule: LS-1 then a further LS-2 on each 5-bit half.
  always_comb begin
    p10_key = p10(key);
    ls1_key = {p10_key[8:5], p10_key[9], p10_key[3:0], p10_key[4]};
    ls3_key = {ls1_key[7:5], ls1_key[9:8], ls1_key[2:0], ls1_key[4:3]};
    k1_d    = p8(ls1_key);
    k2_d    = p8(ls3_key);
  end

`ifdef SDES_RR_EN
  // Pointer holds the last granted channel; resetting to ch1 lets ch0 win the first tie.
  logic last_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
    else                    grant = req_valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       last_q <= 1'b1;
    else if (accept) last_q <= gnt_ch;
  end
`else
  assign grant = req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
`endif

  assign req_ready = (state_q == IDLE) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign gnt_ch    = req_ready[1];

  assign fk_key = (state_q == R2) ? kb_q : ka_q;

  sdes_fk u_fk (
    .st_i  (st_q),
    .key_i (fk_key),
    .st_o  (fk_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      st_q        <= '0;
      ka_q        <= '0;
      kb_q        <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      id_q        <= 1'b0;
      out_id_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // A key write updates k1/k2 only; an accepted or in-flight job keeps its latched kA/kB.
      if (key_wr) begin
        k1_q <= k1_d;
        k2_q <= k2_d;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            st_q <= ip(gnt_ch ? req_data[15:8] : req_data[7:0]);
            id_q <= gnt_ch;
            if (req_mode[gnt_ch] == SDES_DEC) begin
              ka_q <= k2_q;
              kb_q <= k1_q;
            end else begin
              ka_q <= k1_q;
              kb_q <= k2_q;
            end
            state_q <= R1;
          end
        end
        R1: begin
          st_q    <= {fk_out[3:0], fk_out[7:4]};
          state_q <= R2;
        end
        R2: begin
          out_data_q  <= ip_inv(fk_out);
          out_id_q    <= id_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sdes_engine_sched.sv
`timescale 1ns/1ps
module tb_sdes_engine_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        key_wr = 1'b0;
  logic [9:0]  key = '0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_mode = '0;
  logic [15:0] req_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_id;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdes_engine_sched dut (
    .clk       (clk),
    .rstn      (rstn),
    .key_wr    (key_wr),
    .key       (key),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (index tables, written from the S-DES definition) -------------
  typedef int perm_t [10];
  localparam perm_t P10_T = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam perm_t P8_T  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
  localparam perm_t IP_T  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
  localparam perm_t IPI_T = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
  localparam perm_t EP_T  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
  localparam perm_t P4_T  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
  localparam int S0_M [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  localparam int S1_M [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  // Output bit j (1 = MSB) takes input bit p[j] (1 = MSB).
  function automatic logic [9:0] perm(input logic [9:0] x, input int n_in, input int n_out,
                                      input perm_t p);
    logic [9:0] r;
    r = '0;
    for (int j = 1; j <= n_out; j++) r[n_out-j] = x[n_in-p[j-1]];
    return r;
  endfunction

  function automatic void model_keys(input logic [9:0] k, output logic [7:0] k1, output logic [7:0] k2);
    logic [9:0] p, l1, l2, t;
    p  = perm(k, 10, 10, P10_T);
    l1 = {p[8:5], p[9], p[3:0], p[4]};
    l2 = {l1[7:5], l1[9:8], l1[2:0], l1[4:3]};
    t  = perm(l1, 10, 8, P8_T);
    k1 = t[7:0];
    t  = perm(l2, 10, 8, P8_T);
    k2 = t[7:0];
  endfunction

  function automatic logic [7:0] model_fk(input logic [7:0] s, input logic [7:0] k);
    logic [9:0] e, f;
    logic [7:0] m;
    logic [1:0] a, b;
    e = perm({6'b0, s[3:0]}, 4, 8, EP_T);
    m = e[7:0] ^ k;
    a = 2'(S0_M[{m[7], m[4]}][{m[6], m[5]}]);
    b = 2'(S1_M[{m[3], m[0]}][{m[2], m[1]}]);
    f = perm({6'b0, a, b}, 4, 4, P4_T);
    return {s[7:4] ^ f[3:0], s[3:0]};
  endfunction

  function automatic logic [7:0] model_sdes(input logic [7:0] din, input logic [9:0] k, input logic dec);
    logic [7:0] k1, k2, ka, kb, b, c;
    logic [9:0] t;
    model_keys(k, k1, k2);
    ka = dec ? k2 : k1;
    kb = dec ? k1 : k2;
    t  = perm({2'b0, din}, 8, 8, IP_T);
    b  = model_fk(t[7:0], ka);
    c  = model_fk({b[3:0], b[7:4]}, kb);
    t  = perm({2'b0, c}, 8, 8, IPI_T);
    return t[7:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  localparam logic [9:0] KEY_A = 10'b1010000010;

  task automatic load_key(input logic [9:0] k);
    @(negedge clk);
    key    = k;
    key_wr = 1'b1;
    @(negedge clk);
    key_wr = 1'b0;
  endtask

  // Called at a negedge; returns how many further negedges passed before out_valid.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 16) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " valid_drop"}, out_valid, 1'b0);
    check({name, " busy_drop"}, busy, 1'b0);
  endtask

  task automatic run_job(input string name, input int ch, input logic mode,
                         input logic [7:0] din, input logic [7:0] exp);
    int n;
    logic [1:0] want;
    @(negedge clk);
    want = '0;
    want[ch] = 1'b1;
    req_valid = want;
    req_mode[ch] = mode;
    if (ch == 1) req_data[15:8] = din;
    else         req_data[7:0]  = din;
    #1;
    check({name, " grant"}, req_ready, want);
    @(negedge clk);
    req_valid = '0;
    wait_valid(n);
    check({name, " latency"}, n, 2);
    check({name, " data"}, out_data, exp);
    check({name, " id"}, out_id, ch[0]);
    handshake(name);
  endtask

  typedef struct {
    logic [9:0] key;
    int         ch;
    logic       mode;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   n, g, cyc;
    logic [1:0] gnt [4];
    logic [7:0] exp_c [2];
    logic ok;

    vecs[0] = '{KEY_A,         0, 1'b0, 8'b10010111, 8'b00111000};
    vecs[1] = '{KEY_A,         1, 1'b1, 8'b00111000, 8'b10010111};
    vecs[2] = '{KEY_A,         1, 1'b0, 8'b10010111, 8'b00111000};
    vecs[3] = '{KEY_A,         0, 1'b1, 8'b00111000, 8'b10010111};
    vecs[4] = '{10'b1111111111, 0, 1'b0, 8'h5A, 8'h00};
    vecs[5] = '{10'b0111111101, 1, 1'b1, 8'hC3, 8'h00};
    for (int i = 4; i < 6; i++) vecs[i].exp = model_sdes(vecs[i].din, vecs[i].key, vecs[i].mode);

    // Reset state
    #12;
    check("reset req_ready", req_ready, 2'b00);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, 8'h00);
    check("reset out_id", out_id, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset k1", dut.k1_q, 8'h00);
    check("reset k2", dut.k2_q, 8'h00);
    @(negedge clk);
    rstn = 1'b1;

    // Key schedule
    load_key(KEY_A);
    check("k1", dut.k1_q, 8'b10100100);
    check("k2", dut.k2_q, 8'b01000011);

    // Table-driven single jobs
    for (int i = 0; i < 6; i++) begin
      load_key(vecs[i].key);
      run_job($sformatf("vec%0d", i), vecs[i].ch, vecs[i].mode, vecs[i].din, vecs[i].exp);
    end

    // Contention: both channels valid continuously, consumer always ready
    exp_c[0] = model_sdes(8'h11, 10'b0111111101, 1'b0);
    exp_c[1] = model_sdes(8'hE4, 10'b0111111101, 1'b1);
    @(negedge clk);
    req_mode  = 2'b10;
    req_data  = {8'hE4, 8'h11};
    req_valid = 2'b11;
    out_ready = 1'b1;
    g = 0;
    cyc = 0;
    while (g < 4 && cyc < 64) begin
      #1;
      if (req_ready != 2'b00) begin
        check("contention one_hot", $countones(req_ready), 1);
        gnt[g] = req_ready;
        g++;
      end
      if (out_valid) check("contention data", out_data, exp_c[out_id]);
      @(negedge clk);
      cyc++;
    end
    req_valid = 2'b00;
    check("contention grant count", g, 4);
    wait_valid(n);
    check("contention last data", out_data, exp_c[out_id]);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef SDES_RR_EN
      check($sformatf("contention grant%0d", i), gnt[i], (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      check($sformatf("contention grant%0d", i), gnt[i], 2'b01);
`endif
    end

    // Back-pressure: hold OUT for 10 cycles while both channels keep requesting
    load_key(KEY_A);
    @(negedge clk);
    req_mode  = 2'b00;
    req_data  = {8'b10010111, 8'b10010111};
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b11;
    wait_valid(n);
    check("bp latency", n, 2);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 8'b00111000 || out_id !== 1'b0 || req_ready !== 2'b00)
        ok = 1'b0;
    end
    check("bp hold stable", ok, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release valid", out_valid, 1'b0);
    #1;
    check("bp next ready", |req_ready, 1'b1);
    @(negedge clk);
    req_valid = 2'b00;
    check("bp next accepted", busy, 1'b1);
    wait_valid(n);
    check("bp next data", out_data, 8'b00111000);
    handshake("bp next");

    // Key write while a job is in R1: job keeps old keys, next job uses the new key
    @(negedge clk);
    req_data[7:0] = 8'b10010111;
    req_valid     = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    key       = 10'b0;
    key_wr    = 1'b1;
    @(negedge clk);
    key_wr = 1'b0;
    wait_valid(n);
    check("keychg inflight data", out_data, 8'b00111000);
    handshake("keychg inflight");
    run_job("keychg new", 0, 1'b0, 8'b10010111, model_sdes(8'b10010111, 10'b0, 1'b0));

    // Key write in the accept cycle: job uses the old (all-zero) keys
    @(negedge clk);
    req_data[7:0] = 8'h6B;
    req_valid     = 2'b01;
    key           = KEY_A;
    key_wr        = 1'b1;
    @(negedge clk);
    key_wr    = 1'b0;
    req_valid = 2'b00;
    wait_valid(n);
    check("keyacc data", out_data, model_sdes(8'h6B, 10'b0, 1'b0));
    handshake("keyacc");
    run_job("keyacc next", 0, 1'b0, 8'b10010111, 8'b00111000);

    // Reset during R2
    @(negedge clk);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    check("rst r2 busy_before", busy, 1'b1);
    rstn = 1'b0;
    #1;
    check("rst r2 out_valid", out_valid, 1'b0);
    check("rst r2 busy", busy, 1'b0);
    check("rst r2 k1", dut.k1_q, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    run_job("rst zero key", 0, 1'b0, 8'b10010111, model_sdes(8'b10010111, 10'b0, 1'b0));

    // Reset while holding a result in OUT: out_valid drops without a clock edge
    @(negedge clk);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    wait_valid(n);
    check("rst out valid_before", out_valid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("rst out out_valid", out_valid, 1'b0);
    check("rst out busy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    load_key(KEY_A);
    run_job("rst reload", 0, 1'b0, 8'b10010111, 8'b00111000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
